// File: rtl/dfd_timestamp_pkg.sv
// Shared constants for the DFD timestamp block: register offsets, CONFIG and
// STATUS field positions, and the timestamp width legality check.
package dfd_timestamp_pkg;

    // Register offsets relative to the register window base
    localparam int unsigned OFF_TS_LO    = 'h00;
    localparam int unsigned OFF_TS_HI    = 'h04;
    localparam int unsigned OFF_SYNC_LO  = 'h08;
    localparam int unsigned OFF_SYNC_HI  = 'h0C;
    localparam int unsigned OFF_CONFIG   = 'h10;
    localparam int unsigned OFF_STATUS   = 'h14;
    localparam int unsigned OFF_CAP_BASE = 'h20;
    localparam int unsigned CAP_STRIDE   = 8;

    // CONFIG field positions
    localparam int CFG_ARM_BIT    = 0;
    localparam int CFG_MARKER_LSB = 1;
    localparam int CFG_SEL_LSB    = 9;
    localparam int CFG_PRESC_LSB  = 12;
    localparam int CFG_MASK_LSB   = 20;
    localparam int CFG_W          = 28;

    // STATUS field positions
    localparam int STS_VALID_LSB  = 0;
    localparam int STS_OVF_LSB    = 8;

    // Timestamp width limits: the high half must hold at least one bit
    localparam int TS_WIDTH_MIN   = 33;
    localparam int TS_WIDTH_MAX   = 64;

    function automatic bit ts_width_legal(input int w);
        return (w >= TS_WIDTH_MIN) && (w <= TS_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/dfd_ts_capture_chan.sv
// One trigger/capture channel: rising-edge detect, timestamp capture register,
// and the sticky valid / overflow flags. A capture beats a same-cycle clear.
module dfd_ts_capture_chan #(
    parameter int TS_WIDTH = 64
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_trig,
    input  logic                i_cap_en,
    input  logic [TS_WIDTH-1:0] i_ts,
    input  logic                i_clr_valid,
    input  logic                i_clr_ovf,
    output logic                o_rise,
    output logic [TS_WIDTH-1:0] o_capture,
    output logic                o_valid,
    output logic                o_overflow
);

    logic trig_d;
    logic capture_fire;
    logic valid_next;
    logic ovf_next;

    generic_dff #(.WIDTH(1)) u_trig_d (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (1'b1),
        .i_d     (i_trig),
        .o_q     (trig_d)
    );

    assign o_rise       = i_trig & ~trig_d;
    assign capture_fire = o_rise & i_cap_en;

    generic_dff #(.WIDTH(TS_WIDTH)) u_capture (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (capture_fire),
        .i_d     (i_ts),
        .o_q     (o_capture)
    );

    // Flag update: capture sets valid (and overflow if already valid), else W1C clear
    always_comb begin
        valid_next = o_valid;
        ovf_next   = o_overflow;
        if (capture_fire) begin
            valid_next = 1'b1;
        end else if (i_clr_valid) begin
            valid_next = 1'b0;
        end
        if (capture_fire && o_valid) begin
            ovf_next = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_next = 1'b0;
        end
    end

    generic_dff #(.WIDTH(1)) u_valid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (1'b1),
        .i_d     (valid_next),
        .o_q     (o_valid)
    );

    generic_dff #(.WIDTH(1)) u_overflow (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (1'b1),
        .i_d     (ovf_next),
        .o_q     (o_overflow)
    );

endmodule

// File: rtl/generic_dff.sv
// Generic register with synchronous active-high reset and load enable.
module generic_dff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Load on enable, clear on reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/dfd_timestamp_mc.sv
// DFD timestamp block: prescaled free-running timestamp with trigger resync,
// per-channel trigger capture, and an APB register window.
module dfd_timestamp_mc
    import dfd_timestamp_pkg::*;
#(
    parameter int                          DFD_APB_ADDR_WIDTH = 32,
    parameter int                          DFD_APB_DATA_WIDTH = 32,
    parameter logic [DFD_APB_ADDR_WIDTH-1:0] BASE_ADDR        = 'h0,
    parameter logic [DFD_APB_ADDR_WIDTH-1:0] START_OFFSET     = 'h200,
    parameter int                          TS_WIDTH           = 64,
    parameter int                          NUM_TRIG           = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [DFD_APB_ADDR_WIDTH-1:0]   i_paddr,
    input  logic                            i_psel,
    input  logic                            i_penable,
    input  logic                            i_pwrite,
    input  logic [DFD_APB_ADDR_WIDTH/8-1:0] i_pstrb,
    input  logic [DFD_APB_DATA_WIDTH-1:0]   i_pwdata,
    output logic                            o_pready,
    output logic                            o_pslverr,
    output logic [DFD_APB_DATA_WIDTH-1:0]   o_prdata,
    output logic                            o_reg_hit,
    input  logic [NUM_TRIG-1:0]             i_xtrigger,
    input  logic                            i_time_tick,
    output logic [TS_WIDTH-1:0]             o_timestamp,
    output logic [7:0]                      o_debug_marker,
    output logic [NUM_TRIG-1:0]             o_capture_valid
);

    localparam int AW   = DFD_APB_ADDR_WIDTH;
    localparam int HI_W = TS_WIDTH - 32;
    localparam logic [AW-1:0] WIN_BASE = BASE_ADDR + START_OFFSET;

    if (!ts_width_legal(TS_WIDTH) || NUM_TRIG < 1 || NUM_TRIG > 8 ||
        DFD_APB_DATA_WIDTH != 32) begin : g_param_check
        $error("dfd_timestamp_mc: unsupported parameter combination");
    end

    // APB pipeline
    logic          psel_reg;
    logic [AW-1:0] paddr_reg;
    logic [31:0]   pwdata_reg;
    logic          strb_all_reg;
    logic          setup_rd_reg;
    logic          setup_wr_reg;
    logic          pready_reg;
    logic [31:0]   prdata_reg;

    // Core state
    logic [TS_WIDTH-1:0] ts_reg, ts_next;
    logic [TS_WIDTH-1:0] sync_reg, sync_next;
    logic [CFG_W-1:0]    cfg_reg, cfg_next;
    logic [7:0]          presc_reg, presc_next;

    // Decode
    logic [AW-1:0] rel_addr;
    logic [6:0]    rel_lo;
    logic          in_window;
    logic          dec_ts_lo, dec_ts_hi, dec_sync_lo, dec_sync_hi, dec_cfg, dec_sts, dec_cap;
    logic [2:0]    cap_idx;
    logic          addr_hit;
    logic [31:0]   rd_data;
    logic          wr_commit;

    // Channel buses padded to 8 so unused channels read as zero
    logic [7:0]        rise_bus, valid_bus, ovf_bus;
    logic [7:0][63:0]  cap_bus;
    logic [63:0]       ts_ext, sync_ext;

    logic       ts_inc;
    logic       resync_fire;
    logic [2:0] cfg_sel;

    assign rel_addr  = paddr_reg - WIN_BASE;
    assign rel_lo    = rel_addr[6:0];
    assign in_window = ~|rel_addr[AW-1:7];
    assign ts_ext    = 64'(ts_reg);
    assign sync_ext  = 64'(sync_reg);
    assign cap_idx   = rel_lo[5:3] - 3'(OFF_CAP_BASE >> 3);
    assign wr_commit = setup_wr_reg & strb_all_reg;

    // Address decode and read-data mux on the registered address
    always_comb begin
        dec_ts_lo   = 1'b0;
        dec_ts_hi   = 1'b0;
        dec_sync_lo = 1'b0;
        dec_sync_hi = 1'b0;
        dec_cfg     = 1'b0;
        dec_sts     = 1'b0;
        dec_cap     = 1'b0;
        rd_data     = '0;
        if (in_window) begin
            case (rel_lo)
                7'(OFF_TS_LO):   dec_ts_lo   = 1'b1;
                7'(OFF_TS_HI):   dec_ts_hi   = 1'b1;
                7'(OFF_SYNC_LO): dec_sync_lo = 1'b1;
                7'(OFF_SYNC_HI): dec_sync_hi = 1'b1;
                7'(OFF_CONFIG):  dec_cfg     = 1'b1;
                7'(OFF_STATUS):  dec_sts     = 1'b1;
                default: begin
                    dec_cap = (rel_lo[1:0] == 2'b00) &&
                              (rel_lo >= 7'(OFF_CAP_BASE)) &&
                              (rel_lo <  7'(OFF_CAP_BASE + CAP_STRIDE * NUM_TRIG));
                end
            endcase
        end
        if (dec_ts_lo)   rd_data = ts_ext[31:0];
        if (dec_ts_hi)   rd_data = ts_ext[63:32];
        if (dec_sync_lo) rd_data = sync_ext[31:0];
        if (dec_sync_hi) rd_data = sync_ext[63:32];
        if (dec_cfg)     rd_data = 32'(cfg_reg);
        if (dec_sts)     rd_data = {16'h0, ovf_bus, valid_bus};
        if (dec_cap)     rd_data = rel_lo[2] ? cap_bus[cap_idx][63:32] : cap_bus[cap_idx][31:0];
        addr_hit = dec_ts_lo | dec_ts_hi | dec_sync_lo | dec_sync_hi | dec_cfg | dec_sts | dec_cap;
    end

    // APB pipeline: register the setup phase, answer one cycle later on a hit only
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            psel_reg     <= 1'b0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            strb_all_reg <= 1'b0;
            setup_rd_reg <= 1'b0;
            setup_wr_reg <= 1'b0;
            pready_reg   <= 1'b0;
            prdata_reg   <= '0;
        end else begin
            psel_reg     <= i_psel;
            paddr_reg    <= i_paddr;
            pwdata_reg   <= i_pwdata;
            strb_all_reg <= &i_pstrb;
            setup_rd_reg <= i_psel & ~i_penable & ~i_pwrite;
            setup_wr_reg <= i_psel & ~i_penable & i_pwrite;
            pready_reg   <= (setup_rd_reg | setup_wr_reg) & addr_hit;
            prdata_reg   <= (setup_rd_reg & addr_hit) ? rd_data : '0;
        end
    end

    assign cfg_sel     = cfg_reg[CFG_SEL_LSB +: 3];
    assign resync_fire = cfg_reg[CFG_ARM_BIT] & rise_bus[cfg_sel];

    // Next-state for prescaler, timestamp, SYNC and CONFIG
    always_comb begin
        presc_next = presc_reg;
        ts_inc     = 1'b0;
        if (resync_fire) begin
            presc_next = '0;
        end else if (i_time_tick) begin
            if (presc_reg == cfg_reg[CFG_PRESC_LSB +: 8]) begin
                presc_next = '0;
                ts_inc     = 1'b1;
            end else begin
                presc_next = presc_reg + 8'd1;
            end
        end

        // Resync beats increment; an APB half-write then overrides just that half
        ts_next = ts_reg;
        if (resync_fire) begin
            ts_next = sync_reg;
        end else if (ts_inc) begin
            ts_next = ts_reg + TS_WIDTH'(1);
        end
        if (wr_commit && dec_ts_lo) ts_next[31:0]          = pwdata_reg;
        if (wr_commit && dec_ts_hi) ts_next[TS_WIDTH-1:32] = pwdata_reg[HI_W-1:0];

        sync_next = sync_reg;
        if (wr_commit && dec_sync_lo) sync_next[31:0]          = pwdata_reg;
        if (wr_commit && dec_sync_hi) sync_next[TS_WIDTH-1:32] = pwdata_reg[HI_W-1:0];

        cfg_next = cfg_reg;
        if (wr_commit && dec_cfg) begin
            cfg_next = pwdata_reg[CFG_W-1:0];
        end else if (resync_fire) begin
            cfg_next[CFG_ARM_BIT] = 1'b0;
        end
    end

    // Core state registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ts_reg    <= '0;
            sync_reg  <= '0;
            cfg_reg   <= '0;
            presc_reg <= '0;
        end else begin
            ts_reg    <= ts_next;
            sync_reg  <= sync_next;
            cfg_reg   <= cfg_next;
            presc_reg <= presc_next;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
        if (gi < NUM_TRIG) begin : g_inst
            logic [TS_WIDTH-1:0] cap_q;
            dfd_ts_capture_chan #(.TS_WIDTH(TS_WIDTH)) u_chan (
                .i_clk       (i_clk),
                .i_reset     (i_reset),
                .i_trig      (i_xtrigger[gi]),
                .i_cap_en    (cfg_reg[CFG_MASK_LSB + gi]),
                .i_ts        (ts_reg),
                .i_clr_valid (wr_commit & dec_sts & pwdata_reg[STS_VALID_LSB + gi]),
                .i_clr_ovf   (wr_commit & dec_sts & pwdata_reg[STS_OVF_LSB + gi]),
                .o_rise      (rise_bus[gi]),
                .o_capture   (cap_q),
                .o_valid     (valid_bus[gi]),
                .o_overflow  (ovf_bus[gi])
            );
            assign cap_bus[gi] = 64'(cap_q);
        end else begin : g_pad
            assign rise_bus[gi]  = 1'b0;
            assign valid_bus[gi] = 1'b0;
            assign ovf_bus[gi]   = 1'b0;
            assign cap_bus[gi]   = '0;
        end
    end

    assign o_pready        = pready_reg;
    assign o_pslverr       = 1'b0;
    assign o_prdata        = prdata_reg;
    assign o_reg_hit       = psel_reg & addr_hit;
    assign o_timestamp     = ts_reg;
    assign o_debug_marker  = cfg_reg[CFG_MARKER_LSB +: 8];
    assign o_capture_valid = valid_bus[NUM_TRIG-1:0];

endmodule

// File: doc/dfd_timestamp_mc.md
DFD_TIMESTAMP_MC -- requirements
Module: dfd_timestamp_mc

Interface
REQ-001 SHALL have parameter DFD_APB_ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DFD_APB_DATA_WIDTH, default 32, APB data width; only 32 is supported.
REQ-003 SHALL have parameter BASE_ADDR, default 'h0, block base address.
REQ-004 SHALL have parameter START_OFFSET, default 'h200, offset of the register window from BASE_ADDR.
REQ-005 SHALL have parameter TS_WIDTH, default 64, timestamp width; legal range 33..64.
REQ-006 SHALL have parameter NUM_TRIG, default 4, number of trigger/capture channels; legal range 1..8.
REQ-007 SHALL use one clock and a synchronous, active-high reset, with ports ordered as follows.
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_paddr  in  ADDR_W  APB address
- i_psel / i_penable / i_pwrite  in  1  APB controls
- i_pstrb  in  ADDR_W/8  byte strobes; a write occurs only when all strobes are set
- i_pwdata  in  32  APB write data
- o_pready / o_pslverr  out  1  ready, error (error tied 0)
- o_prdata  out  32  read data; 0 when o_pready is low
- o_reg_hit  out  1  registered psel AND decoded address hit
- i_xtrigger  in  NUM_TRIG  asynchronous-free trigger levels
- i_time_tick  in  1  timebase tick
- o_timestamp  out  TS_WIDTH  live counter
- o_debug_marker  out  8  CONFIG[8:1]
- o_capture_valid  out  NUM_TRIG  STATUS valid bits

Function
REQ-008 SHALL register psel, paddr, pwdata, &pstrb, and setup-phase read/write (psel & ~penable) one cycle; o_pready SHALL assert the cycle after, only on a hit; misses SHALL never assert pready.
REQ-009 SHALL implement this map, relative to BASE_ADDR+START_OFFSET:
- 0x00/0x04: TS low/high, RW
- 0x08/0x0C: SYNC low/high, RW
- 0x10: CONFIG, RW
- 0x14: STATUS, RW1C
- 0x20+8n / 0x24+8n: CAPTURE[n] low/high, RO
REQ-010 SHALL read all bits of TS, SYNC and CAPTURE at and above TS_WIDTH as 0 and SHALL ignore writes to them.
REQ-011 SHALL define CONFIG as follows; other bits read 0.
- bit0 resync_arm
- [8:1] debug marker
- [11:9] resync trigger select
- [19:12] prescale P
- [27:20] capture enable mask
REQ-012 SHALL detect trigger rising edges against a one-cycle delayed copy of i_xtrigger, reset to 0.
REQ-013 SHALL keep a prescale counter that advances on each i_time_tick; the tick on which the counter equals P SHALL increment the timestamp and clear the counter; P=0 increments on every tick.
REQ-014 SHALL wrap the timestamp from all-ones to 0 with no flag.
REQ-015 SHALL, when resync_arm=1 and the selected trigger has a rising edge, load SYNC into TS, clear the prescale counter and clear resync_arm, all on the same clock edge.
REQ-016 SHALL apply TS update priority APB write > resync load > increment > hold; a TS half-write SHALL change only that half.
REQ-017 SHALL, on a rising edge of an enabled channel n, copy the pre-update o_timestamp into CAPTURE[n] and set valid[n]; if valid[n] is already 1, SHALL overwrite and set overflow[n].
REQ-018 SHALL define STATUS as valid in [7:0] and overflow in [15:8]; writing 1 clears a bit, and a capture on the same cycle as a clear SHALL win.
REQ-019 SHALL latch a selected trigger edge with resync_arm=0 nowhere; that edge is lost.
REQ-020 SHALL let a trigger select of NUM_TRIG or above never match.

Reset
REQ-021 SHALL reset every register to 0, including TS, SYNC, CONFIG, STATUS, captures, edge flops, the prescale counter and APB pipeline flops.
REQ-022 SHALL drive all outputs to 0 the cycle after reset; a reset asserted mid-transfer SHALL abort it with no pready.

Structure
REQ-023 SHALL place register offsets, CONFIG/STATUS field positions and the TS_WIDTH legality check in package dfd_timestamp_pkg.
REQ-024 SHALL instantiate one sub-module per channel, dfd_ts_capture_chan, containing the edge detect, capture register, valid and overflow; flops SHALL use generic_dff.

Verification
REQ-025 SHALL cover: P=3, 8 ticks -> TS goes from 0 to 2, with increments on ticks 4 and 8.
REQ-026 SHALL cover: SYNC=0x1_0000_0000, CONFIG=0x1 (select 0), pulse trig0 -> TS=0x1_0000_0000 next cycle and CONFIG[0]=0.
REQ-027 SHALL cover: TS=0xFFFF_FFFF_FFFF_FFFF, one tick -> TS=0.
REQ-028 SHALL cover: mask=0x3, trig1 pulsed twice -> CAPTURE[1] holds the second value and STATUS=0x0202; write 0x0202 -> STATUS=0.
REQ-029 SHALL cover: APB write of TS low on the same cycle as a resync and a tick -> the APB data wins for the low half and the high half takes the SYNC high value.
REQ-030 SHALL cover: read of 0x18 -> no pready, no hit; TS_WIDTH=40 high read -> bits [31:8] are 0.
